// File: rtl/execute_md_stage.sv
// execute_md_stage: EX stage of a 5-stage MIPS pipeline with the EX/MEM register,
// operand forwarding, an extended ALU and an iterative multiply/divide unit with
// HI/LO registers.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   ip_flush            - turn the current EX instruction into a bubble, abort mul/div
//   ip_* operands       - rs/rt/immediate, forward sources (MEM, WB) and selects FA/FB
//   ip_* controls       - ALU_op, ALU_src, RegDst and pass-through memory/writeback controls
//   op_stall            - combinational; upstream holds PC and ID/EX while high
//   op_md_busy          - mul/div FSM not idle
//   op_md_state         - debug view of the mul/div FSM state
//   op_* EX/MEM outputs - registered result, store data, branch target, dest reg, controls
//   op_overflow         - signed-overflow trap flag
// Build option: define OVERFLOW_TRAP_EN to trap signed overflow on add/sub
// (funct 20/22 and ALU_op=00); otherwise op_overflow is 0 and arithmetic wraps.
// Handshake: there is no valid/ready pair; op_stall high means "the instruction in
// EX has not finished, hold it". Each cycle in which op_stall or ip_flush is high,
// or the instruction is a mul/div, a bubble (all zeros) is loaded into EX/MEM.
module execute_md_stage #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10,
  parameter int REG_AW = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      ip_flush,
  input  logic [5:0]                ip_function_opcode,
  input  logic [$clog2(DATA_W)-1:0] ip_shamt,
  input  logic [PC_W-1:0]           ip_PC_plus_4,
  input  logic [DATA_W-1:0]         ip_read_data_1,
  input  logic [DATA_W-1:0]         ip_read_data_2,
  input  logic [DATA_W-1:0]         ip_immediate,
  input  logic [REG_AW-1:0]         ip_dest_reg_R_type,
  input  logic [REG_AW-1:0]         ip_dest_reg_I_type,
  input  logic [1:0]                ip_ALU_op,
  input  logic                      ip_ALU_src,
  input  logic                      ip_RegDst,
  input  logic                      ip_MemtoReg,
  input  logic                      ip_RegWrite,
  input  logic                      ip_read_en,
  input  logic                      ip_write_en,
  input  logic                      ip_branch,
  input  logic [DATA_W-1:0]         ip_ALU_result_MEM,
  input  logic [DATA_W-1:0]         ip_read_data_WB,
  input  logic [1:0]                ip_FA,
  input  logic [1:0]                ip_FB,
  output logic                      op_stall,
  output logic                      op_md_busy,
  output logic [1:0]                op_md_state,
  output logic                      op_zero,
  output logic                      op_MemtoReg,
  output logic                      op_RegWrite,
  output logic                      op_read_en,
  output logic                      op_write_en,
  output logic                      op_branch,
  output logic [DATA_W-1:0]         op_ALU_result,
  output logic [DATA_W-1:0]         op_memory_write_data,
  output logic [PC_W-1:0]           op_Add_result,
  output logic [REG_AW-1:0]         op_dest_reg,
  output logic                      op_overflow
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_BUSY = 2'd1, MD_DONE = 2'd2} md_state_t;

  md_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               div_q, div_d, sa_q, sa_d, sb_q, sb_d;
  logic [DATA_W-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, dvsr_q, dvsr_d;
  logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0]  alu_q, alu_d, wdata_q, wdata_d;
  logic [PC_W-1:0]    add_q, add_d;
  logic [REG_AW-1:0]  dest_q, dest_d;
  logic               zero_q, zero_d, m2r_q, m2r_d, rw_q, rw_d;
  logic               rd_q, rd_d, wr_q, wr_d, br_q, br_d;

  logic [DATA_W-1:0]  a, b_fwd, b, sum, diff, res;
  logic               is_md, md_signed, sa, sb, stall, bubble, trap;
  logic [DATA_W-1:0]  mag_a, mag_b;

  always_comb begin
    case (ip_FA)
      2'b10:   a = ip_ALU_result_MEM;
      2'b01:   a = ip_read_data_WB;
      default: a = ip_read_data_1;
    endcase
    case (ip_FB)
      2'b10:   b_fwd = ip_ALU_result_MEM;
      2'b01:   b_fwd = ip_read_data_WB;
      default: b_fwd = ip_read_data_2;
    endcase
  end

  // Immediate select sits after the forwarding mux so stores keep the forwarded rt.
  assign b    = ip_ALU_src ? ip_immediate : b_fwd;
  assign sum  = a + b;
  assign diff = a - b;

  assign is_md     = (ip_ALU_op == 2'b10) && (ip_function_opcode[5:2] == 4'b0110);
  assign md_signed = ~ip_function_opcode[0];
  assign sa        = md_signed & a[DATA_W-1];
  assign sb        = md_signed & b_fwd[DATA_W-1];
  assign mag_a     = sa ? -a : a;
  assign mag_b     = sb ? -b_fwd : b_fwd;

  always_comb begin
    res = '0;
    case (ip_ALU_op)
      2'b00: res = sum;
      2'b01: res = diff;
      2'b11: res = b;
      default: begin
        case (ip_function_opcode)
          6'h20, 6'h21: res = sum;
          6'h22, 6'h23: res = diff;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
          6'h2B: res = {{(DATA_W-1){1'b0}}, (a < b)};
          6'h00: res = b_fwd << ip_shamt;
          6'h02: res = b_fwd >> ip_shamt;
          6'h03: res = $unsigned($signed(b_fwd) >>> ip_shamt);
          6'h10: res = hi_q;
          6'h12: res = lo_q;
          default: res = '0;
        endcase
      end
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic ovf_q, ovf_d, add_chk, sub_chk;
  assign add_chk = (ip_ALU_op == 2'b00) ||
                   ((ip_ALU_op == 2'b10) && (ip_function_opcode == 6'h20));
  assign sub_chk = (ip_ALU_op == 2'b10) && (ip_function_opcode == 6'h22);
  always_comb begin
    ovf_d = 1'b0;
    if (!bubble) begin
      if (add_chk)
        ovf_d = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      else if (sub_chk)
        ovf_d = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
    end
  end
  always_ff @(posedge clock) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end
  assign trap        = ovf_d;
  assign op_overflow = ovf_q;
`else
  assign trap        = 1'b0;
  assign op_overflow = 1'b0;
`endif

  // Mul/div datapath, one iteration per BUSY cycle.
  // Multiply: acc_lo holds the multiplier, dvsr the multiplicand; shift-add right.
  // Divide: acc_lo holds the dividend/quotient, acc_hi the partial remainder.
  logic [DATA_W:0]     m_sum, shifted;
  logic [DATA_W-1:0]   step_hi, step_lo, rem_sub;
  logic [2*DATA_W-1:0] prod;
  logic                borrow;

  assign m_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvsr_q} : '0);
  assign shifted = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign borrow  = shifted < {1'b0, dvsr_q};
  assign rem_sub = shifted[DATA_W-1:0] - dvsr_q;

  always_comb begin
    if (div_q) begin
      step_hi = borrow ? shifted[DATA_W-1:0] : rem_sub;
      step_lo = {acc_lo_q[DATA_W-2:0], ~borrow};
    end else begin
      step_hi = m_sum[DATA_W:1];
      step_lo = {m_sum[0], acc_lo_q[DATA_W-1:1]};
    end
    prod = (sa_q ^ sb_q) ? -{step_hi, step_lo} : {step_hi, step_lo};
  end

  assign stall  = ~reset & ~ip_flush &
                  (((state_q == MD_IDLE) & is_md) | (state_q == MD_BUSY));
  assign bubble = ip_flush | stall | is_md;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    dvsr_d   = dvsr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: begin
        if (is_md && !ip_flush) begin
          state_d  = MD_BUSY;
          cnt_d    = '0;
          div_d    = ip_function_opcode[1];
          sa_d     = sa;
          sb_d     = sb;
          acc_hi_d = '0;
          acc_lo_d = ip_function_opcode[1] ? mag_a : mag_b;
          dvsr_d   = ip_function_opcode[1] ? mag_b : mag_a;
        end
      end
      MD_BUSY: begin
        if (ip_flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = MD_DONE;
            if (div_q) begin
              // Divide by zero: all-ones quotient; remainder ends as the dividend.
              lo_d = (dvsr_q == '0) ? '1 : ((sa_q ^ sb_q) ? -step_lo : step_lo);
              hi_d = sa_q ? -step_hi : step_hi;
            end else begin
              hi_d = prod[2*DATA_W-1:DATA_W];
              lo_d = prod[DATA_W-1:0];
            end
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    alu_d   = bubble ? '0 : res;
    wdata_d = bubble ? '0 : b_fwd;
    zero_d  = ~bubble & (res == '0);
    add_d   = bubble ? '0 : ip_PC_plus_4 + {ip_immediate[PC_W-3:0], 2'b00};
    dest_d  = bubble ? '0 : (ip_RegDst ? ip_dest_reg_R_type : ip_dest_reg_I_type);
    m2r_d   = ~bubble & ip_MemtoReg;
    rw_d    = ~bubble & ip_RegWrite & ~trap;
    rd_d    = ~bubble & ip_read_en;
    wr_d    = ~bubble & ip_write_en;
    br_d    = ~bubble & ip_branch;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= MD_IDLE;  cnt_q <= '0;     div_q <= 1'b0;
      sa_q <= 1'b0;        sb_q <= 1'b0;    acc_hi_q <= '0;
      acc_lo_q <= '0;      dvsr_q <= '0;    hi_q <= '0;
      lo_q <= '0;          alu_q <= '0;     wdata_q <= '0;
      add_q <= '0;         dest_q <= '0;    zero_q <= 1'b0;
      m2r_q <= 1'b0;       rw_q <= 1'b0;    rd_q <= 1'b0;
      wr_q <= 1'b0;        br_q <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  div_q <= div_d;
      sa_q <= sa_d;        sb_q <= sb_d;    acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d; dvsr_q <= dvsr_d; hi_q <= hi_d;
      lo_q <= lo_d;        alu_q <= alu_d;  wdata_q <= wdata_d;
      add_q <= add_d;      dest_q <= dest_d; zero_q <= zero_d;
      m2r_q <= m2r_d;      rw_q <= rw_d;    rd_q <= rd_d;
      wr_q <= wr_d;        br_q <= br_d;
    end
  end

  assign op_stall             = stall;
  assign op_md_busy           = (state_q != MD_IDLE);
  assign op_md_state          = state_q;
  assign op_zero              = zero_q;
  assign op_MemtoReg          = m2r_q;
  assign op_RegWrite          = rw_q;
  assign op_read_en           = rd_q;
  assign op_write_en          = wr_q;
  assign op_branch            = br_q;
  assign op_ALU_result        = alu_q;
  assign op_memory_write_data = wdata_q;
  assign op_Add_result        = add_q;
  assign op_dest_reg          = dest_q;

endmodule
